// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/HALT control for a 16-bit
// datapath with external register file and ALU.
module instr_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    input  logic [15:0] rf_rdata1,
    output logic [2:0]  rf_waddr,
    output logic        rf_we,
    output logic [1:0]  rf_wsel,
    output logic [4:0]  alu_op,
    output logic [7:0]  imm8,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic [15:0] pc,
    output logic        halted,
    output logic        instr_done,
    output logic        illegal_op
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SHFT = 5'd10, OP_MOV  = 5'd11,
        OP_JMP  = 5'd12, OP_JGO  = 5'd13, OP_JLO  = 5'd14, OP_JEO  = 5'd15,
        OP_HLT  = 5'd16, OP_RST  = 5'd17, OP_SETH = 5'd18, OP_SETL = 5'd19
    } opcode_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [3:0]  flags_q;      // {Z, N, C, V}
    logic        rf_we_q;
    logic        halted_q;
    logic        done_q;
    logic        illegal_q;

    logic [4:0]  op;
    logic        is_alu_d;
    logic        wr_en_d;
    logic        jump_taken_d;
    logic [1:0]  wsel_d;

    assign op = ir_q[15:11];

    always_comb begin
        is_alu_d     = (op >= OP_ADD) && (op <= OP_SHFT);
        wr_en_d      = is_alu_d || (op == OP_MOV) || (op == OP_SETH) || (op == OP_SETL);
        wsel_d       = 2'd0;
        jump_taken_d = 1'b0;
        case (op)
            OP_MOV:  wsel_d = 2'd1;
            OP_SETH: wsel_d = 2'd2;
            OP_SETL: wsel_d = 2'd3;
            default: wsel_d = 2'd0;
        endcase
        case (op)
            OP_JMP:  jump_taken_d = 1'b1;
            OP_JGO:  jump_taken_d = !flags_q[3] && !flags_q[2];
            OP_JLO:  jump_taken_d = flags_q[2];
            OP_JEO:  jump_taken_d = flags_q[3];
            default: jump_taken_d = 1'b0;
        endcase
    end

    // Write/retire/illegal strobes are registered on the DECODE->EXEC edge so
    // they are high for exactly the EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            flags_q   <= '0;
            rf_we_q   <= 1'b0;
            halted_q  <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            rf_we_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (imem_valid) begin
                        ir_q    <= imem_data;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    pc_q      <= pc_q + 16'd1;
                    rf_we_q   <= wr_en_d;
                    done_q    <= 1'b1;
                    illegal_q <= (op > OP_SETL);
                    state_q   <= EXEC;
                end
                EXEC: begin
                    state_q <= FETCH;
                    if (is_alu_d) begin
                        flags_q <= {alu_z, alu_n, alu_c, alu_v};
                    end
                    if (jump_taken_d) begin
                        pc_q <= rf_rdata1;
                    end
                    if (op == OP_HLT) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                    if (op == OP_RST) begin
                        pc_q    <= RESET_PC;
                        flags_q <= '0;
                    end
                end
                HALT: state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Request is gated by rst so it stays low while reset is held.
    assign imem_req   = (state_q == FETCH) && !rst;
    assign imem_addr  = pc_q;
    assign rf_raddr1  = ir_q[10:8];
    assign rf_raddr2  = ir_q[7:5];
    assign rf_waddr   = ((op == OP_SETH) || (op == OP_SETL)) ? ir_q[10:8] : ir_q[4:2];
    assign rf_wsel    = wsel_d;
    assign rf_we      = rf_we_q;
    assign alu_op     = op;
    assign imm8       = ir_q[7:0];
    assign pc         = pc_q;
    assign halted     = halted_q;
    assign instr_done = done_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; inputs change and outputs
// are sampled on the falling clock edge.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [15:0] rf_rdata1;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic [4:0]  alu_op;
    logic [7:0]  imm8;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic [15:0] pc;
    logic        halted, instr_done, illegal_op;

    int checks = 0;
    int errors = 0;

    instr_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_waddr(rf_waddr), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .alu_op(alu_op), .imm8(imm8),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .pc(pc), .halted(halted), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] r1,
                                        input logic [2:0] r2, input logic [2:0] qr);
        return {op, r1, r2, qr, 2'b00};
    endfunction

    // Starts in FETCH at a falling edge; returns at the falling edge inside EXEC.
    task automatic issue(input logic [15:0] ins);
        imem_valid = 1'b1;
        imem_data  = ins;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = '0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; imem_valid = 1'b0; imem_data = '0; rf_rdata1 = '0;
        alu_z = 0; alu_n = 0; alu_c = 0; alu_v = 0;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h exp 0000", pc); end
        checks++; if ({rf_we, halted, instr_done, illegal_op} !== 4'b0000) begin
            errors++; $display("FAIL rst_strobes: got %b exp 0000", {rf_we, halted, instr_done, illegal_op}); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_release_req: got %b exp 1", imem_req); end
    endtask

    task automatic test_add;
        issue(enc(5'd1, 3'd1, 3'd2, 3'd3));
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL add_we: got %b exp 1", rf_we); end
        checks++; if (rf_waddr !== 3'd3) begin errors++; $display("FAIL add_waddr: got %0d exp 3", rf_waddr); end
        checks++; if (rf_wsel !== 2'd0) begin errors++; $display("FAIL add_wsel: got %0d exp 0", rf_wsel); end
        checks++; if ({rf_raddr1, rf_raddr2} !== {3'd1, 3'd2}) begin
            errors++; $display("FAIL add_raddr: got %0d/%0d exp 1/2", rf_raddr1, rf_raddr2); end
        checks++; if (alu_op !== 5'd1) begin errors++; $display("FAIL add_aluop: got %0d exp 1", alu_op); end
        checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL add_done: got %b exp 1", instr_done); end
        checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL add_pc: got %h exp 0001", pc); end
        @(negedge clk);
        checks++; if ({rf_we, instr_done} !== 2'b00) begin
            errors++; $display("FAIL add_pulse_end: got %b exp 00", {rf_we, instr_done}); end
        checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL add_next_addr: got %h exp 0001", imem_addr); end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({imem_req, rf_we, imem_addr} !== {1'b1, 1'b0, 16'h0001}) begin
                errors++; $display("FAIL stall_%0d: got req=%b we=%b addr=%h exp 1 0 0001", i, imem_req, rf_we, imem_addr); end
            @(negedge clk);
        end
        issue(enc(5'd11, 3'd4, 3'd0, 3'd5));
        checks++; if ({rf_we, rf_wsel, rf_waddr, instr_done} !== {1'b1, 2'd1, 3'd5, 1'b1}) begin
            errors++; $display("FAIL mov_exec: got we=%b sel=%0d wa=%0d done=%b exp 1 1 5 1", rf_we, rf_wsel, rf_waddr, instr_done); end
        @(negedge clk);
    endtask

    task automatic test_jump;
        alu_z = 1'b1;
        issue(enc(5'd3, 3'd1, 3'd2, 3'd3));
        @(negedge clk);
        alu_z = 1'b0; rf_rdata1 = 16'h0040;
        issue(enc(5'd15, 3'd1, 3'd0, 3'd0));
        checks++; if ({rf_we, instr_done, pc} !== {1'b0, 1'b1, 16'h0004}) begin
            errors++; $display("FAIL jeo_exec: got we=%b done=%b pc=%h exp 0 1 0004", rf_we, instr_done, pc); end
        @(negedge clk);
        checks++; if (imem_addr !== 16'h0040) begin errors++; $display("FAIL jeo_taken: got %h exp 0040", imem_addr); end
        issue(enc(5'd3, 3'd1, 3'd2, 3'd3));
        @(negedge clk);
        issue(enc(5'd15, 3'd1, 3'd0, 3'd0));
        @(negedge clk);
        checks++; if (imem_addr !== 16'h0042) begin errors++; $display("FAIL jeo_not_taken: got %h exp 0042", imem_addr); end
        rf_rdata1 = 16'hFFFF;
        issue(enc(5'd13, 3'd1, 3'd0, 3'd0));
        @(negedge clk);
        checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL jgo_taken: got %h exp ffff", imem_addr); end
    endtask

    task automatic test_wrap;
        issue(16'h0000);
        checks++; if ({rf_we, instr_done, pc} !== {1'b0, 1'b1, 16'h0000}) begin
            errors++; $display("FAIL nop_wrap_exec: got we=%b done=%b pc=%h exp 0 1 0000", rf_we, instr_done, pc); end
        @(negedge clk);
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL nop_wrap_addr: got %h exp 0000", imem_addr); end
    endtask

    task automatic test_illegal_and_set;
        issue({5'd25, 11'd0});
        checks++; if ({illegal_op, rf_we, instr_done} !== 3'b101) begin
            errors++; $display("FAIL illegal_exec: got ill/we/done=%b exp 101", {illegal_op, rf_we, instr_done}); end
        @(negedge clk);
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %b exp 0", illegal_op); end
        issue({5'd18, 3'd6, 8'hA5});
        checks++; if ({rf_we, rf_wsel, rf_waddr, imm8} !== {1'b1, 2'd2, 3'd6, 8'hA5}) begin
            errors++; $display("FAIL seth_exec: got we=%b sel=%0d wa=%0d imm=%h exp 1 2 6 a5", rf_we, rf_wsel, rf_waddr, imm8); end
        @(negedge clk);
        issue({5'd19, 3'd2, 8'h3C});
        checks++; if ({rf_we, rf_wsel, rf_waddr, imm8} !== {1'b1, 2'd3, 3'd2, 8'h3C}) begin
            errors++; $display("FAIL setl_exec: got we=%b sel=%0d wa=%0d imm=%h exp 1 3 2 3c", rf_we, rf_wsel, rf_waddr, imm8); end
        @(negedge clk);
    endtask

    task automatic test_rst_opcode;
        alu_n = 1'b1;
        issue(enc(5'd3, 3'd1, 3'd2, 3'd3));
        @(negedge clk);
        alu_n = 1'b0; rf_rdata1 = 16'h0010;
        issue(enc(5'd12, 3'd1, 3'd0, 3'd0));
        @(negedge clk);
        checks++; if (imem_addr !== 16'h0010) begin errors++; $display("FAIL jmp_addr: got %h exp 0010", imem_addr); end
        issue(enc(5'd17, 3'd0, 3'd0, 3'd0));
        checks++; if ({instr_done, pc} !== {1'b1, 16'h0011}) begin
            errors++; $display("FAIL rstop_exec: got done=%b pc=%h exp 1 0011", instr_done, pc); end
        @(negedge clk);
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rstop_addr: got %h exp 0000", imem_addr); end
        rf_rdata1 = 16'h0080;
        issue(enc(5'd14, 3'd1, 3'd0, 3'd0));
        @(negedge clk);
        checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL rstop_flags_clr: got %h exp 0001", imem_addr); end
    endtask

    task automatic test_halt;
        issue(enc(5'd16, 3'd0, 3'd0, 3'd0));
        checks++; if ({instr_done, halted} !== 2'b10) begin
            errors++; $display("FAIL hlt_exec: got done/halted=%b exp 10", {instr_done, halted}); end
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            checks++; if ({halted, imem_req, rf_we} !== 3'b100) begin
                errors++; $display("FAIL halt_%0d: got halted/req/we=%b exp 100", i, {halted, imem_req, rf_we}); end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++; if ({halted, imem_req, pc} !== {1'b0, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL halt_rst: got halted=%b req=%b pc=%h exp 0 0 0000", halted, imem_req, pc); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            errors++; $display("FAIL halt_refetch: got req=%b addr=%h exp 1 0000", imem_req, imem_addr); end
    endtask

    task automatic test_async_rst_exec;
        issue(enc(5'd1, 3'd1, 3'd2, 3'd3));
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL arst_pre_we: got %b exp 1", rf_we); end
        rst = 1'b1;
        #1;
        checks++; if ({rf_we, instr_done, illegal_op, halted, imem_req} !== 5'b00000) begin
            errors++; $display("FAIL arst_strobes: got %b exp 00000", {rf_we, instr_done, illegal_op, halted, imem_req}); end
        checks++; if ({pc, alu_op, rf_waddr} !== {16'h0000, 5'd0, 3'd0}) begin
            errors++; $display("FAIL arst_state: got pc=%h op=%0d wa=%0d exp 0000 0 0", pc, alu_op, rf_waddr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL arst_release: got %b exp 1", imem_req); end
    endtask

    task automatic test_back_to_back;
        issue(enc(5'd2, 3'd3, 3'd4, 3'd7));
        checks++; if ({rf_we, rf_waddr, pc} !== {1'b1, 3'd7, 16'h0001}) begin
            errors++; $display("FAIL b2b_first: got we=%b wa=%0d pc=%h exp 1 7 0001", rf_we, rf_waddr, pc); end
        @(negedge clk);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b exp 0", rf_we); end
        issue(enc(5'd8, 3'd5, 3'd6, 3'd1));
        checks++; if ({rf_we, rf_waddr, alu_op, pc} !== {1'b1, 3'd1, 5'd8, 16'h0002}) begin
            errors++; $display("FAIL b2b_second: got we=%b wa=%0d op=%0d pc=%h exp 1 1 8 0002", rf_we, rf_waddr, alu_op, pc); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_stall();
        test_jump();
        test_wrap();
        test_illegal_and_set();
        test_rst_opcode();
        test_halt();
        test_async_rst_exec();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
